// File: rtl/pipeline_latches_pkg.sv
// pipeline_latches_pkg: shared CPU types, opcode constants and pipeline payload layouts.
package pipeline_latches_pkg;
    typedef logic [31:0] word_t;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_HALT = 6'h3f;
    typedef struct packed {
        word_t npc;
        word_t instr;
    } ifid_t;
    typedef struct packed {
        word_t npc, rdat1, rdat2, imm;
        logic [31:0] ctrl;
    } idex_t;
    typedef struct packed {
        word_t alu, wdat, npc;
        logic [15:0] ctrl;
    } exmem_t;
    typedef struct packed {
        word_t alu, dload, npc;
        logic [7:0] ctrl;
    } memwb_t;
    localparam int IFID_W  = $bits(ifid_t);
    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);
endpackage

// File: rtl/pipeline_latches_if.sv
// pipeline_latches_if: stage payloads, hazard controls and stage status between datapath and pipeline registers.
interface pipeline_latches_if
    import pipeline_latches_pkg::*;
#(
    parameter int IDW  = IFID_W,
    parameter int EXW  = IDEX_W,
    parameter int MEMW = EXMEM_W,
    parameter int WBW  = MEMWB_W
);
    logic ihit, dmem_req, dhit, fdEN, dx_flush, branch_flush, mem_halt_d;
    word_t if_instr;
    logic [IDW-1:0] if_d, ifid_q;
    logic [EXW-1:0] id_d, idex_q;
    logic [MEMW-1:0] ex_d, exmem_q;
    logic [WBW-1:0] mem_d, memwb_q;
    logic ifid_v, idex_v, exmem_v, memwb_v;
    word_t dec_instr, ex_instr, mem_instr;
    logic halt, flush_pend;
    modport master (
        output ihit, dmem_req, dhit, fdEN, dx_flush, branch_flush, mem_halt_d,
        output if_instr, if_d, id_d, ex_d, mem_d,
        input  ifid_q, idex_q, exmem_q, memwb_q, ifid_v, idex_v, exmem_v, memwb_v,
        input  dec_instr, ex_instr, mem_instr, halt, flush_pend
    );
    modport slave (
        input  ihit, dmem_req, dhit, fdEN, dx_flush, branch_flush, mem_halt_d,
        input  if_instr, if_d, id_d, ex_d, mem_d,
        output ifid_q, idex_q, exmem_q, memwb_q, ifid_v, idex_v, exmem_v, memwb_v,
        output dec_instr, ex_instr, mem_instr, halt, flush_pend
    );
endinterface

// File: rtl/pipeline_latches_pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register with valid bit; bubble clears it, load captures, otherwise holds.
module pipe_stage_reg #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         bubble,
    input  logic         dv,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         v
);
    always_ff @(posedge CLK or posedge RST)
        if (RST) {v, q} <= '0;
        else if (bubble) {v, q} <= '0;
        else if (load) {v, q} <= {dv, d};
endmodule

// File: rtl/pipeline_latches.sv
// pipeline_latches: the four MIPS pipeline registers with stall, bubble, squash, freeze and sticky halt control.
module pipeline_latches
    import pipeline_latches_pkg::*;
#(
    parameter int IDW  = IFID_W,
    parameter int EXW  = IDEX_W,
    parameter int MEMW = EXMEM_W,
    parameter int WBW  = MEMWB_W
) (
    input logic CLK,
    input logic RST,
    pipeline_latches_if.slave bus
);
    logic halt_q, flush_q, freeze, run, sq;
    logic [IDW+31:0] ifid_r;
    logic [EXW+31:0] idex_r;
    logic [MEMW+31:0] exmem_r;
    assign freeze = bus.dmem_req & ~bus.dhit;
    assign run = ~halt_q & ~freeze;
    assign sq = bus.branch_flush | flush_q;
    // A flush seen during a freeze is replayed on the first edge the pipe moves again.
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            halt_q <= 1'b0;
            flush_q <= 1'b0;
        end else if (!halt_q) begin
            flush_q <= freeze & (flush_q | bus.branch_flush);
            halt_q <= ~freeze & bus.exmem_v & bus.mem_halt_d;
        end
    pipe_stage_reg #(.W(IDW + 32)) u_ifid (
        .CLK(CLK), .RST(RST),
        .load(run & bus.fdEN & bus.ihit),
        .bubble(run & (sq | (bus.fdEN & ~bus.ihit))),
        .dv(1'b1), .d({bus.if_instr, bus.if_d}),
        .q(ifid_r), .v(bus.ifid_v)
    );
    pipe_stage_reg #(.W(EXW + 32)) u_idex (
        .CLK(CLK), .RST(RST),
        .load(run), .bubble(run & (sq | bus.dx_flush)),
        .dv(bus.ifid_v), .d({bus.dec_instr, bus.id_d}),
        .q(idex_r), .v(bus.idex_v)
    );
    pipe_stage_reg #(.W(MEMW + 32)) u_exmem (
        .CLK(CLK), .RST(RST),
        .load(run), .bubble(1'b0),
        .dv(bus.idex_v), .d({bus.ex_instr, bus.ex_d}),
        .q(exmem_r), .v(bus.exmem_v)
    );
    pipe_stage_reg #(.W(WBW)) u_memwb (
        .CLK(CLK), .RST(RST),
        .load(run), .bubble(1'b0),
        .dv(bus.exmem_v), .d(bus.mem_d),
        .q(bus.memwb_q), .v(bus.memwb_v)
    );
    assign {bus.dec_instr, bus.ifid_q} = ifid_r;
    assign {bus.ex_instr, bus.idex_q} = idex_r;
    assign {bus.mem_instr, bus.exmem_q} = exmem_r;
    assign bus.halt = halt_q;
    assign bus.flush_pend = flush_q;
endmodule

// File: tb/tb_pipeline_latches.sv
// tb_pipeline_latches: directed scenarios with a scoreboard of instruction words expected to reach the MEM stage.
module tb_pipeline_latches;
    import pipeline_latches_pkg::*;
    logic CLK = 1'b0;
    logic RST;
    int checks = 0;
    int errors = 0;
    word_t sb[$];
    logic run_s;
    word_t exp_w;
    localparam word_t LW3 = {OP_LW, 26'h3};
    localparam word_t HLT = {OP_HALT, 26'h0};

    always #5 CLK = ~CLK;

    pipeline_latches_if bus ();
    pipeline_latches dut (.CLK(CLK), .RST(RST), .bus(bus));

    task automatic chk(input string n, input logic [191:0] a, input logic [191:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input word_t w, input logic ih);
        bus.ihit = ih;
        bus.if_instr = w;
        bus.if_d = {~w, w};
        bus.id_d = {5{w}};
        bus.ex_d = EXMEM_W'({4{w}});
        bus.mem_d = MEMWB_W'({4{w}});
    endtask

    task automatic idle();
        drive(32'h0, 1'b0);
        bus.dmem_req = 0;
        bus.dhit = 0;
        bus.fdEN = 1;
        bus.dx_flush = 0;
        bus.branch_flush = 0;
        bus.mem_halt_d = 0;
    endtask

    task automatic fetch(input word_t w, input logic keep);
        drive(w, 1'b1);
        if (keep) sb.push_back(w);
        tick();
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_ifid"}, {bus.ifid_v, bus.ifid_q}, 0);
        chk({n, "_idex"}, {bus.idex_v, bus.idex_q}, 0);
        chk({n, "_exmem"}, {bus.exmem_v, bus.exmem_q}, 0);
        chk({n, "_memwb"}, {bus.memwb_v, bus.memwb_q}, 0);
        chk({n, "_instr"}, {bus.dec_instr, bus.ex_instr, bus.mem_instr}, 0);
        chk({n, "_hf"}, {bus.halt, bus.flush_pend}, 0);
    endtask

    task automatic areset();
        #2 RST = 1;
        #1 chk_zero("async_rst");
        sb.delete();
        tick();
        RST = 0;
        idle();
    endtask

    task automatic fill(input word_t base);
        for (int i = 1; i <= 4; i++) fetch(base + i, 1'b1);
        chk("fill_valids", {bus.ifid_v, bus.idex_v, bus.exmem_v, bus.memwb_v}, 4'b1111);
        chk("fill_instr", {bus.dec_instr, bus.ex_instr, bus.mem_instr}, {base + 4, base + 3, base + 2});
        chk("fill_ifid_q", bus.ifid_q, {~(base + 4), base + 4});
        chk("fill_idex_q", bus.idex_q, {5{base + 32'd4}});
        chk("fill_memwb_q", bus.memwb_q, MEMWB_W'({4{base + 32'd4}}));
    endtask

    // Pops the next expected MEM-stage word whenever a valid instruction advances into EX/MEM.
    always @(posedge CLK) begin
        run_s = !RST && !bus.halt && !(bus.dmem_req && !bus.dhit);
        #1;
        if (run_s && bus.exmem_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got %0h want none", bus.mem_instr);
            end else begin
                exp_w = sb.pop_front();
                chk("sb_mem_instr", bus.mem_instr, exp_w);
            end
        end
    end

    initial begin
        RST = 1;
        idle();
        tick();
        tick();
        chk_zero("reset");
        RST = 0;
        // fill: w1..w4, with w3 a load
        fetch(32'h1000_0001, 1'b1);
        fetch(32'h1000_0002, 1'b1);
        fetch(LW3, 1'b1);
        fetch(32'h1000_0004, 1'b1);
        chk("fill1_valids", {bus.ifid_v, bus.idex_v, bus.exmem_v, bus.memwb_v}, 4'b1111);
        chk("fill1_instr", {bus.dec_instr, bus.ex_instr, bus.mem_instr}, {32'h1000_0004, LW3, 32'h1000_0002});
        // load-use stall: hold IF/ID, bubble ID/EX, lw moves to MEM
        bus.fdEN = 0;
        bus.dx_flush = 1;
        drive(32'h1000_0005, 1'b1);
        tick();
        chk("stall_ifid", {bus.ifid_v, bus.dec_instr, bus.ifid_q}, {1'b1, 32'h1000_0004, ~32'h1000_0004, 32'h1000_0004});
        chk("stall_idex", {bus.idex_v, bus.ex_instr}, 0);
        chk("stall_exmem", {bus.exmem_v, bus.mem_instr}, {1'b1, LW3});
        bus.fdEN = 1;
        bus.dx_flush = 0;
        fetch(32'h1000_0005, 1'b1);
        chk("resume_exmem_v", bus.exmem_v, 1'b0);
        fetch(32'h1000_0006, 1'b0);
        chk("resume_instr", {bus.dec_instr, bus.ex_instr, bus.mem_instr}, {32'h1000_0006, 32'h1000_0005, 32'h1000_0004});
        // memory freeze with branch flush in its first cycle
        bus.dmem_req = 1;
        bus.branch_flush = 1;
        fetch(32'h1000_0007, 1'b0);
        bus.branch_flush = 0;
        for (int i = 0; i < 3; i++) begin
            chk("frz_pend", bus.flush_pend, 1'b1);
            chk("frz_instr", {bus.dec_instr, bus.ex_instr, bus.mem_instr}, {32'h1000_0006, 32'h1000_0005, 32'h1000_0004});
            chk("frz_q", {bus.ifid_q, bus.memwb_q}, {~32'h1000_0006, 32'h1000_0006, MEMWB_W'({4{32'h1000_0006}})});
            if (i < 2) tick();
        end
        bus.dhit = 1;
        fetch(32'h1000_0008, 1'b0);
        chk("unfrz_valids", {bus.ifid_v, bus.idex_v, bus.exmem_v, bus.memwb_v}, 4'b0011);
        chk("unfrz_pend", bus.flush_pend, 1'b0);
        chk("unfrz_instr", {bus.dec_instr, bus.mem_instr}, {32'h0, 32'h1000_0005});
        bus.dmem_req = 0;
        bus.dhit = 0;
        // fetch misses
        fetch(32'h1000_0009, 1'b1);
        fetch(32'h1000_000a, 1'b1);
        drive(32'hdead_0000, 1'b0);
        tick();
        chk("miss1", {bus.ifid_v, bus.idex_v, bus.exmem_v, bus.ex_instr}, {3'b011, 32'h1000_000a});
        tick();
        chk("miss2", {bus.ifid_v, bus.idex_v, bus.exmem_v, bus.mem_instr}, {3'b001, 32'h1000_000a});
        // halt reaches writeback
        fetch(HLT, 1'b1);
        drive(32'h0, 1'b0);
        tick();
        tick();
        chk("pre_halt", {bus.exmem_v, bus.mem_instr, bus.halt}, {1'b1, HLT, 1'b0});
        bus.mem_halt_d = 1;
        drive(32'h1000_000c, 1'b1);
        tick();
        chk("halt_set", {bus.halt, bus.memwb_v, bus.exmem_v, bus.dec_instr}, {2'b11, 1'b0, 32'h1000_000c});
        chk("sb_empty_halt", sb.size(), 0);
        for (int i = 0; i < 10; i++) begin
            bus.ihit = 1'($urandom);
            bus.dmem_req = 1'($urandom);
            bus.dhit = 1'($urandom);
            bus.fdEN = 1'($urandom);
            bus.dx_flush = 1'($urandom);
            bus.branch_flush = 1'($urandom);
            bus.mem_halt_d = 1'($urandom);
            bus.if_instr = $urandom;
            tick();
            chk("halt_hold", {bus.halt, bus.flush_pend, bus.ifid_v, bus.exmem_v, bus.memwb_v, bus.dec_instr},
                {5'b10101, 32'h1000_000c});
            chk("halt_hold_q", bus.memwb_q, MEMWB_W'({4{32'h1000_000c}}));
        end
        idle();
        areset();
        // reset in the middle of a freeze with a deferred flush
        bus.dmem_req = 1;
        bus.branch_flush = 1;
        tick();
        chk("pend_before_rst", bus.flush_pend, 1'b1);
        bus.branch_flush = 0;
        tick();
        areset();
        fill(32'h2000_0000);
        drive(32'h0, 1'b0);
        tick();
        tick();
        tick();
        chk("sb_empty_end", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
